// File: rtl/router_pkg.sv
// Shared constants and helpers for the N-port star router.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package router_pkg;

    localparam int DEF_NPORTS     = 4;
    localparam int DEF_DW         = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int PERF_CNT_W     = 16;

    // Ceiling log2, usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/router_rr_arb.sv
// Round-robin arbiter for one output: one-hot grant, search starts at the pointer.
// Latency: combinational grant; pointer updates on the edge of a grant.
// Backpressure: no grant and pointer hold while en_i is low.
module router_rr_arb
    import router_pkg::*;
#(
    parameter int N = DEF_NPORTS
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_o
);

    localparam int PW = (clog2(N) < 1) ? 1 : clog2(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;

    // Two passes: first the requesters at or above the pointer, then wrap to the bottom.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        if (en_i) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req_i[i] && (i >= int'(ptr_q))) begin
                    found    = 1'b1;
                    gnt_o[i] = 1'b1;
                    ptr_d    = PW'((i + 1) % N);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!found && req_i[i]) begin
                    found    = 1'b1;
                    gnt_o[i] = 1'b1;
                    ptr_d    = PW'((i + 1) % N);
                end
            end
        end
    end

    // Pointer moves past the winner; it holds when nothing was granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/router_nport.sv
// N-port star router: per-input FIFO, dest decode, per-output RR arbiter, registered crossbar.
// Latency: flit written at edge t can be presented at out_valid on edge t+1.
// Backpressure: out_ready low stalls the output register and its requesters; full FIFO drops in_ready.
// Optional: ROUTER_PERF_CNT_EN adds per-output 16-bit saturating transfer counters (perf_cnt_o).
module router_nport
    import router_pkg::*;
#(
    parameter int NPORTS     = DEF_NPORTS,
    parameter int DW         = DEF_DW,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NPORTS*DW-1:0]   in_data_i,
    input  logic [NPORTS-1:0]      in_valid_i,
    output logic [NPORTS-1:0]      in_ready_o,
    output logic [NPORTS*DW-1:0]   out_data_o,
    output logic [NPORTS-1:0]      out_valid_o,
    input  logic [NPORTS-1:0]      out_ready_i,
    output logic [NPORTS-1:0]      route_err_o
`ifdef ROUTER_PERF_CNT_EN
    ,
    output logic [NPORTS*PERF_CNT_W-1:0] perf_cnt_o
`endif
);

    localparam int DEST_W = (clog2(NPORTS) < 1) ? 1 : clog2(NPORTS);
    localparam int PTR_W  = clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [DW-1:0]     head     [NPORTS];
    logic [DEST_W-1:0] dest     [NPORTS];
    logic [NPORTS-1:0] req      [NPORTS];
    logic [NPORTS-1:0] gnt      [NPORTS];
    logic [NPORTS-1:0] not_empty;
    logic [NPORTS-1:0] bad_dest;
    logic [NPORTS-1:0] push;
    logic [NPORTS-1:0] pop;
    logic [NPORTS-1:0] load;

    // Request matrix: req[j][i] means input i's head flit wants output j.
    always_comb begin
        for (int j = 0; j < NPORTS; j++) begin
            req[j] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                req[j][i] = not_empty[i] && (int'(dest[i]) == j);
            end
        end
    end

    // An input pops when it is granted anywhere or its head is undeliverable.
    always_comb begin
        pop = bad_dest;
        for (int j = 0; j < NPORTS; j++) begin
            pop = pop | gnt[j];
        end
    end

    assign route_err_o = bad_dest;

    for (genvar i = 0; i < NPORTS; i++) begin : g_in
        logic [DW-1:0]    mem_q [FIFO_DEPTH];
        logic [PTR_W-1:0] wr_ptr_q;
        logic [PTR_W-1:0] rd_ptr_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             ready_q;

        assign push[i]       = in_valid_i[i] && ready_q;
        assign in_ready_o[i] = ready_q;
        assign not_empty[i]  = (cnt_q != '0);
        assign head[i]       = mem_q[rd_ptr_q];
        assign dest[i]       = head[i][DEST_W-1:0];
        assign bad_dest[i]   = not_empty[i] && (int'(dest[i]) >= NPORTS);

        // Occupancy: simultaneous push and pop leave the count unchanged.
        always_comb begin
            cnt_d = cnt_q;
            if (push[i] && !pop[i]) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!push[i] && pop[i]) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        // Pointers, count and the registered not-full flag.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                ready_q  <= 1'b1;
            end else begin
                if (push[i]) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                cnt_q   <= cnt_d;
                ready_q <= (cnt_d != FULL_CNT);
            end
        end

        // Storage needs no reset; the count decides what is valid.
        always_ff @(posedge clk_i) begin
            if (push[i]) begin
                mem_q[wr_ptr_q] <= in_data_i[i*DW +: DW];
            end
        end
    end

    for (genvar j = 0; j < NPORTS; j++) begin : g_out
        logic          vld_q;
        logic [DW-1:0] dat_q;
        logic [DW-1:0] sel_dat;

        assign load[j]                = !vld_q || out_ready_i[j];
        assign out_valid_o[j]         = vld_q;
        assign out_data_o[j*DW +: DW] = dat_q;

        router_rr_arb #(
            .N (NPORTS)
        ) u_arb (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .req_i  (req[j]),
            .en_i   (load[j]),
            .gnt_o  (gnt[j])
        );

        // Crossbar column: pick the head of the granted input.
        always_comb begin
            sel_dat = '0;
            for (int i = 0; i < NPORTS; i++) begin
                if (gnt[j][i]) begin
                    sel_dat = head[i];
                end
            end
        end

        // Output register: load on grant, empty when drained with nothing new.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end else if (load[j]) begin
                vld_q <= |gnt[j];
                if (|gnt[j]) begin
                    dat_q <= sel_dat;
                end
            end
        end

`ifdef ROUTER_PERF_CNT_EN
        logic [PERF_CNT_W-1:0] perf_q;

        assign perf_cnt_o[j*PERF_CNT_W +: PERF_CNT_W] = perf_q;

        // Saturating count of completed output transfers.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                perf_q <= '0;
            end else if (vld_q && out_ready_i[j] && (perf_q != '1)) begin
                perf_q <= perf_q + 1'b1;
            end
        end
`endif
    end

endmodule

// File: tb/tb_router_nport.sv
`timescale 1ns/1ps
module tb_router_nport;

    localparam int NP  = 4;
    localparam int DW  = 8;
    localparam int NP3 = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP*DW-1:0]  in_data;
    logic [NP-1:0]     in_valid;
    logic [NP-1:0]     in_ready;
    logic [NP*DW-1:0]  out_data;
    logic [NP-1:0]     out_valid;
    logic [NP-1:0]     out_ready;
    logic [NP-1:0]     route_err;
    logic [NP3*DW-1:0] in_data3;
    logic [NP3-1:0]    in_valid3;
    logic [NP3-1:0]    in_ready3;
    logic [NP3*DW-1:0] out_data3;
    logic [NP3-1:0]    out_valid3;
    logic [NP3-1:0]    out_ready3;
    logic [NP3-1:0]    route_err3;
`ifdef ROUTER_PERF_CNT_EN
    logic [NP*16-1:0]  perf_cnt;
    logic [NP3*16-1:0] perf_cnt3;
`endif

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    logic [7:0] exp_q [NP*NP][$];
    int         xfer_cnt [NP];
    int         log_src [$];
    int         log_cyc [$];
    int         tx_left [NP];
    int         tx_seq  [NP];
    logic [1:0] tx_dst  [NP];
    bit         rand_mode;
    int         left;

    router_nport #(.NPORTS(NP), .DW(DW), .FIFO_DEPTH(4)) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .route_err_o (route_err)
`ifdef ROUTER_PERF_CNT_EN
        , .perf_cnt_o (perf_cnt)
`endif
    );

    router_nport #(.NPORTS(NP3), .DW(DW), .FIFO_DEPTH(4)) u_dut3 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_data_i   (in_data3),
        .in_valid_i  (in_valid3),
        .in_ready_o  (in_ready3),
        .out_data_o  (out_data3),
        .out_valid_o (out_valid3),
        .out_ready_i (out_ready3),
        .route_err_o (route_err3)
`ifdef ROUTER_PERF_CNT_EN
        , .perf_cnt_o (perf_cnt3)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int outstanding();
        int s = 0;
        for (int k = 0; k < NP*NP; k++) s += exp_q[k].size();
        return s;
    endfunction

    // Scoreboard: accepted writes push into a per (input,output) queue; transfers pop and compare.
    always @(negedge clk) begin : monitor
        logic [7:0] f;
        int         key;
        if (rst_n) begin
            for (int i = 0; i < NP; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    f = in_data[i*DW +: DW];
                    exp_q[i*NP + int'(f[1:0])].push_back(f);
                end
            end
            for (int j = 0; j < NP; j++) begin
                if (out_valid[j] && out_ready[j]) begin
                    f = out_data[j*DW +: DW];
                    xfer_cnt[j]++;
                    if (j == 1) begin
                        log_src.push_back(int'(f[3:2]));
                        log_cyc.push_back(cyc);
                    end
                    check("route_dest", 64'(f[1:0]), 64'(j));
                    key = int'(f[3:2]) * NP + j;
                    if (exp_q[key].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_flit out%0d: got %0h expected none", j, f);
                    end else begin
                        check("flit_order", 64'(f), 64'(exp_q[key].pop_front()));
                    end
                end
            end
        end
    end

    // Drives each input's pending flits, holding valid until accepted.
    task automatic run_streams(input int budget, output int remaining);
        int         c;
        logic [NP-1:0] acc;
        c = 0;
        remaining = tx_left[0] + tx_left[1] + tx_left[2] + tx_left[3];
        while (remaining > 0 && c < budget) begin
            for (int i = 0; i < NP; i++) begin
                if (tx_left[i] > 0 && (!rand_mode || $urandom_range(3) != 0)) begin
                    in_valid[i] = 1'b1;
                    in_data[i*DW +: DW] = {4'(tx_seq[i]), 2'(i), tx_dst[i]};
                end else begin
                    in_valid[i] = 1'b0;
                end
            end
            if (rand_mode) out_ready = 4'($urandom);
            acc = in_valid & in_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NP; i++) begin
                if (acc[i]) begin
                    tx_left[i]--;
                    tx_seq[i]++;
                    if (rand_mode) tx_dst[i] = 2'($urandom_range(3));
                end
            end
            c++;
            remaining = tx_left[0] + tx_left[1] + tx_left[2] + tx_left[3];
        end
        in_valid = '0;
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        out_ready = '1;
        while ((outstanding() > 0 || out_valid != '0) && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain_outstanding", 64'(outstanding()), 64'd0);
        check("drain_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = '1;
        in_valid3 = '0; in_data3 = '0; out_ready3 = '1; rand_mode = 1'b0;
        for (int i = 0; i < NP; i++) begin
            tx_left[i] = 0; tx_seq[i] = 0; tx_dst[i] = 2'd0; xfer_cnt[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst_in_ready", 64'(in_ready), 64'hF);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_data", 64'(out_data), 64'h0);
        check("rst_route_err", 64'(route_err), 64'h0);
`ifdef ROUTER_PERF_CNT_EN
        check("rst_perf", 64'(perf_cnt), 64'h0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single flit A2 on input 0 -> output 2, one edge after the write
        in_valid[0] = 1'b1;
        in_data[7:0] = 8'hA2;
        @(posedge clk);
        #1;
        in_valid = '0;
        check("single_no_bypass", 64'(out_valid), 64'h0);
        @(posedge clk);
        #1;
        check("single_valid", 64'(out_valid), 64'b0100);
        check("single_data", 64'(out_data[23:16]), 64'hA2);
        drain(20);

        // Contention: 4 inputs x 8 flits to output 1
        log_src.delete();
        log_cyc.delete();
        for (int i = 0; i < NP; i++) begin
            tx_left[i] = 8; tx_seq[i] = 0; tx_dst[i] = 2'd1;
        end
        run_streams(200, left);
        check("contention_sent", 64'(left), 64'd0);
        drain(100);
        check("contention_count", 64'(log_src.size()), 64'd32);
        if (log_src.size() == 32) begin
            for (int k = 0; k < 32; k++) check("rr_order", 64'(log_src[k]), 64'(k % NP));
            check("back_to_back", 64'(log_cyc[31] - log_cyc[0]), 64'd31);
        end

        // Backpressure: output 3 stalled while input 1 streams to it
        out_ready = 4'b0111;
        tx_left[1] = 8; tx_seq[1] = 0; tx_dst[1] = 2'd3;
        run_streams(10, left);
        check("bp_accepted", 64'(8 - left), 64'd5);
        check("bp_in_ready1", 64'(in_ready[1]), 64'd0);
        check("bp_out_valid3", 64'(out_valid[3]), 64'd1);
        check("bp_out_data3", 64'(out_data[31:24]), 64'h07);
        out_ready = '1;
        run_streams(50, left);
        check("bp_sent", 64'(left), 64'd0);
        drain(50);

        // Randomized traffic with random destinations and random out_ready
        rand_mode = 1'b1;
        for (int i = 0; i < NP; i++) begin
            tx_left[i] = 40; tx_dst[i] = 2'($urandom_range(3));
        end
        run_streams(3000, left);
        rand_mode = 1'b0;
        check("rand_sent", 64'(left), 64'd0);
        drain(300);

        // Async reset mid-stream with flits held in outputs and FIFOs
        out_ready = '0;
        for (int i = 0; i < NP; i++) begin
            tx_left[i] = 3; tx_dst[i] = 2'(i);
        end
        run_streams(50, left);
        check("pre_rst_sent", 64'(left), 64'd0);
        check("pre_rst_valid", 64'(out_valid), 64'hF);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = '0;
        for (int k = 0; k < NP*NP; k++) exp_q[k].delete();
        for (int j = 0; j < NP; j++) xfer_cnt[j] = 0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'h0);
        check("arst_out_data", 64'(out_data), 64'h0);
        check("arst_in_ready", 64'(in_ready), 64'hF);
`ifdef ROUTER_PERF_CNT_EN
        check("arst_perf", 64'(perf_cnt), 64'h0);
`endif
        #4;
        rst_n = 1'b1;
        out_ready = '1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            check("post_rst_idle", 64'(out_valid), 64'h0);
        end

        // Bad destination on the 3-port router: 8'h03 on input 2
        in_valid3 = 3'b100;
        in_data3[23:16] = 8'h03;
        @(posedge clk);
        #1;
        in_valid3 = '0;
        check("bad_route_err_pulse", 64'(route_err3), 64'b100);
        check("bad_no_valid_a", 64'(out_valid3), 64'h0);
        @(posedge clk);
        #1;
        check("bad_route_err_clear", 64'(route_err3), 64'h0);
        check("bad_no_valid_b", 64'(out_valid3), 64'h0);
        @(posedge clk);
        #1;
        check("bad_no_valid_c", 64'(out_valid3), 64'h0);
        check("bad_in_ready", 64'(in_ready3), 64'b111);
        in_valid3 = 3'b100;
        in_data3[23:16] = 8'h09;
        @(posedge clk);
        #1;
        in_valid3 = '0;
        @(posedge clk);
        #1;
        check("p3_good_valid", 64'(out_valid3), 64'b010);
        check("p3_good_data", 64'(out_data3[15:8]), 64'h09);

        drain(20);
`ifdef ROUTER_PERF_CNT_EN
        for (int j = 0; j < NP; j++) check("perf_count", 64'(perf_cnt[j*16 +: 16]), 64'(xfer_cnt[j]));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
